// File: rtl/imm_extend_pipe.sv
// Registered immediate generator: extends the selected instruction field at push
// time and queues {illegal, immediate} in a small in-order buffer for execute.
module imm_extend_pipe #(
  parameter int N     = 16,
  parameter int SM_W  = 5,
  parameter int LG_W  = 8,
  parameter int DIS_W = 11,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] inst,
  input  logic         ext_sign,
  input  logic [2:0]   ext_op,
  input  logic         flush,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] ext_imm,
  output logic         out_illegal
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Valid/ready: a transfer happens on a rising edge where valid && ready are both
  // high; the producer holds its payload stable while valid is high and ready is low.

  logic [N-1:0]     imm_q [DEPTH];
  logic [DEPTH-1:0] ill_q;
  logic [PW-1:0]    rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [N-1:0] sm_ext, lg_ext, dis_ext, lg_shift, lg_zext;
  logic [N-1:0] new_imm;
  logic         new_ill;
  logic         push, pop;
  logic         unused_ok;

  assign unused_ok = ^inst[N-1:DIS_W];

  always_comb begin
    sm_ext   = {{(N-SM_W){ext_sign & inst[SM_W-1]}}, inst[SM_W-1:0]};
    lg_ext   = {{(N-LG_W){ext_sign & inst[LG_W-1]}}, inst[LG_W-1:0]};
    dis_ext  = {{(N-DIS_W){ext_sign & inst[DIS_W-1]}}, inst[DIS_W-1:0]};
    lg_zext  = {{(N-LG_W){1'b0}}, inst[LG_W-1:0]};
    lg_shift = lg_zext << LG_W;
    new_imm  = sm_ext;
    new_ill  = 1'b0;
    case (ext_op)
      3'b000:  new_imm = sm_ext;
      3'b001:  new_imm = lg_ext;
      3'b010:  new_imm = dis_ext;
      3'b011:  new_imm = lg_shift;
      default: begin
        new_imm = sm_ext;
        new_ill = 1'b1;
      end
    endcase
  end

  // Ready depends only on registered occupancy, never on out_ready.
  assign in_ready    = (cnt_q < CW'(DEPTH));
  assign out_valid   = (cnt_q != '0);
  assign ext_imm     = out_valid ? imm_q[rd_q] : '0;
  assign out_illegal = out_valid ? ill_q[rd_q] : 1'b0;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (flush) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) wr_d = (wr_q == PW'(DEPTH-1)) ? '0 : wr_q + 1'b1;
      if (pop)  rd_d = (rd_q == PW'(DEPTH-1)) ? '0 : rd_q + 1'b1;
      if (push && !pop)      cnt_d = cnt_q + 1'b1;
      else if (!push && pop) cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) imm_q[i] <= '0;
      ill_q <= '0;
    end else if (push && !flush) begin
      imm_q[wr_q] <= new_imm;
      ill_q[wr_q] <= new_ill;
    end
  end

endmodule
